// File: rtl/mdio_responder.sv
// Clause-22 MDIO PHY-side responder: frame decoder, read-data driver and a
// 32 x 16 management register file, all running in the system clock domain.
module mdio_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'd7,
  parameter logic [15:0] PHY_ID1  = 16'h0141,
  parameter logic [15:0] PHY_ID2  = 16'h0CC2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        eth_mdc,
  input  logic        eth_mdio_i,
  output logic        eth_mdio_o,
  output logic        eth_mdio_t,
  output logic        reg_wr_valid,
  output logic [4:0]  reg_wr_addr,
  output logic [15:0] reg_wr_data
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ST    = 3'd1;
  localparam logic [2:0] S_OP    = 3'd2;
  localparam logic [2:0] S_PHYAD = 3'd3;
  localparam logic [2:0] S_REGAD = 3'd4;
  localparam logic [2:0] S_TA    = 3'd5;
  localparam logic [2:0] S_WDATA = 3'd6;
  localparam logic [2:0] S_RDATA = 3'd7;

  localparam logic [5:0] PRE_FULL = 6'd32;

  function automatic logic [15:0] reset_value(input logic [4:0] idx);
    case (idx)
      5'd0:    reset_value = 16'h1140;
      5'd1:    reset_value = 16'h796D;
      5'd2:    reset_value = PHY_ID1;
      5'd3:    reset_value = PHY_ID2;
      default: reset_value = 16'h0000;
    endcase
  endfunction

  logic        mdc_meta_r, mdc_sync_r, mdc_prev_r;
  logic        mdio_meta_r, mdio_sync_r;
  logic        rise_s;
  logic [2:0]  state_r;
  logic [5:0]  pre_cnt_r;
  logic [3:0]  bit_cnt_r;
  logic        op_first_r, op_read_r, foreign_r;
  logic [4:0]  phy_addr_r, reg_addr_r;
  logic [15:0] shift_r;
  logic        wr_pend_r;
  logic [4:0]  wr_addr_r;
  logic [15:0] wr_data_r;
  logic        restore_s;
  logic [15:0] regs_r [32];

  assign rise_s    = mdc_sync_r & ~mdc_prev_r;
  assign restore_s = wr_pend_r & (wr_addr_r == 5'd0) & wr_data_r[15];

  // Two-flop synchronisers for MDC and MDIO plus the MDC edge history.
  always_ff @(posedge clock) begin
    if (reset) begin
      mdc_meta_r  <= 1'b0;
      mdc_sync_r  <= 1'b0;
      mdc_prev_r  <= 1'b0;
      mdio_meta_r <= 1'b0;
      mdio_sync_r <= 1'b0;
    end else begin
      mdc_meta_r  <= eth_mdc;
      mdc_sync_r  <= mdc_meta_r;
      mdc_prev_r  <= mdc_sync_r;
      mdio_meta_r <= eth_mdio_i;
      mdio_sync_r <= mdio_meta_r;
    end
  end

  // Frame FSM; advances one bit per MDC rising edge and owns the pad drive.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= S_IDLE;
      pre_cnt_r  <= 6'd0;
      bit_cnt_r  <= 4'd0;
      op_first_r <= 1'b0;
      op_read_r  <= 1'b0;
      foreign_r  <= 1'b0;
      phy_addr_r <= 5'd0;
      reg_addr_r <= 5'd0;
      shift_r    <= 16'h0000;
      wr_pend_r  <= 1'b0;
      wr_addr_r  <= 5'd0;
      wr_data_r  <= 16'h0000;
      eth_mdio_o <= 1'b0;
      eth_mdio_t <= 1'b1;
    end else begin
      wr_pend_r <= 1'b0;
      if (rise_s) begin
        case (state_r)
          S_IDLE: begin
            // The count is consumed on ST entry so every frame needs a new preamble.
            if (mdio_sync_r) begin
              if (pre_cnt_r != PRE_FULL) pre_cnt_r <= pre_cnt_r + 6'd1;
            end else if (pre_cnt_r == PRE_FULL) begin
              state_r   <= S_ST;
              pre_cnt_r <= 6'd0;
            end else begin
              pre_cnt_r <= 6'd0;
            end
          end
          S_ST: begin
            bit_cnt_r <= 4'd0;
            state_r   <= mdio_sync_r ? S_OP : S_IDLE;
          end
          S_OP: begin
            if (bit_cnt_r == 4'd0) begin
              op_first_r <= mdio_sync_r;
              bit_cnt_r  <= 4'd1;
            end else if (op_first_r != mdio_sync_r) begin
              op_read_r <= op_first_r;
              bit_cnt_r <= 4'd0;
              state_r   <= S_PHYAD;
            end else begin
              state_r <= S_IDLE;
            end
          end
          S_PHYAD: begin
            phy_addr_r <= {phy_addr_r[3:0], mdio_sync_r};
            if (bit_cnt_r == 4'd4) begin
              foreign_r <= ({phy_addr_r[3:0], mdio_sync_r} != PHY_ADDR);
              bit_cnt_r <= 4'd0;
              state_r   <= S_REGAD;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
          S_REGAD: begin
            reg_addr_r <= {reg_addr_r[3:0], mdio_sync_r};
            if (bit_cnt_r == 4'd4) begin
              bit_cnt_r <= 4'd0;
              state_r   <= S_TA;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
          S_TA: begin
            if (bit_cnt_r == 4'd0) begin
              bit_cnt_r <= 4'd1;
              shift_r   <= regs_r[reg_addr_r];
              if (op_read_r && !foreign_r) begin
                eth_mdio_o <= 1'b0;
                eth_mdio_t <= 1'b0;
              end
            end else begin
              bit_cnt_r <= 4'd0;
              if (op_read_r) begin
                eth_mdio_o <= shift_r[15] & ~foreign_r;
                shift_r    <= {shift_r[14:0], 1'b0};
                state_r    <= S_RDATA;
              end else begin
                state_r <= S_WDATA;
              end
            end
          end
          S_RDATA: begin
            if (bit_cnt_r == 4'd15) begin
              eth_mdio_o <= 1'b0;
              eth_mdio_t <= 1'b1;
              bit_cnt_r  <= 4'd0;
              state_r    <= S_IDLE;
            end else begin
              eth_mdio_o <= shift_r[15] & ~foreign_r;
              shift_r    <= {shift_r[14:0], 1'b0};
              bit_cnt_r  <= bit_cnt_r + 4'd1;
            end
          end
          S_WDATA: begin
            shift_r <= {shift_r[14:0], mdio_sync_r};
            if (bit_cnt_r == 4'd15) begin
              wr_pend_r <= ~foreign_r;
              wr_addr_r <= reg_addr_r;
              wr_data_r <= {shift_r[14:0], mdio_sync_r};
              bit_cnt_r <= 4'd0;
              state_r   <= S_IDLE;
            end else begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end
          default: state_r <= S_IDLE;
        endcase
      end
    end
  end

  // Write strobe outputs, one cycle behind the completed write frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      reg_wr_valid <= 1'b0;
      reg_wr_addr  <= 5'd0;
      reg_wr_data  <= 16'h0000;
    end else begin
      reg_wr_valid <= wr_pend_r;
      if (wr_pend_r) begin
        reg_wr_addr <= wr_addr_r;
        reg_wr_data <= wr_data_r;
      end
    end
  end

  // Register file; registers 1..3 only ever hold their reset values.
  always_ff @(posedge clock) begin
    if (reset || restore_s) begin
      for (int i = 0; i < 32; i++) regs_r[i] <= reset_value(5'(i));
    end else if (wr_pend_r && ((wr_addr_r == 5'd0) || (wr_addr_r > 5'd3))) begin
      regs_r[wr_addr_r] <= {(wr_addr_r != 5'd0) & wr_data_r[15], wr_data_r[14:0]};
    end
  end

endmodule

// File: doc/mdio_responder.md
MDIO_RESPONDER -- requirements
Module: mdio_responder

Interface
REQ-001 SHALL have parameter PHY_ADDR, default 5'd7, the PHY address this responder answers.
REQ-002 SHALL have parameter PHY_ID1, default 16'h0141, the reset value of register 2.
REQ-003 SHALL have parameter PHY_ID2, default 16'h0CC2, the reset value of register 3.
REQ-004 SHALL have port clock  input  1  system clock; the only clock; its frequency is at least 8x the eth_mdc frequency.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port eth_mdc  input  1  management clock from the station; asynchronous to clock.
REQ-007 SHALL have port eth_mdio_i  input  1  MDIO pad input.
REQ-008 SHALL have port eth_mdio_o  output  1  MDIO drive value.
REQ-009 SHALL have port eth_mdio_t  output  1  tristate control; 1 = released (high-Z), 0 = driving eth_mdio_o.
REQ-010 SHALL have port reg_wr_valid  output  1  one-cycle pulse on each accepted register write.
REQ-011 SHALL have port reg_wr_addr  output  5  register address of the write flagged by reg_wr_valid.
REQ-012 SHALL have port reg_wr_data  output  16  data of the write flagged by reg_wr_valid.

Function
REQ-013 SHALL synchronise eth_mdc and eth_mdio_i through two flops each and detect an MDC rising edge as sync_mdc=1 and previous sync_mdc=0.
REQ-014 SHALL sample sync_mdio only on a detected rising edge; all frame bits are counted in rising edges.
REQ-015 SHALL implement the Clause-22 frame FSM with states IDLE, ST, OP, PHYAD, REGAD, TA, WDATA, RDATA.
REQ-016 IDLE: SHALL count consecutive 1 bits, saturating at 32; a 0 bit when count is below 32 clears the count.
REQ-017 IDLE: a 0 bit with count = 32 SHALL be taken as the first ST bit and SHALL move the FSM to ST.
REQ-018 ST: 1 SHALL move to OP; 0 SHALL return to IDLE with the count cleared.
REQ-019 OP: SHALL collect 2 bits; 10 = read and 01 = write go to PHYAD; 00 or 11 SHALL return to IDLE.
REQ-020 PHYAD and REGAD: SHALL collect 5 bits each, MSB first.
REQ-021 PHYAD: an address not equal to PHY_ADDR SHALL mark the frame foreign; the FSM SHALL still track bits through the end of the frame.
REQ-022 TA on read: SHALL keep eth_mdio_t=1 for TA bit 1, then drive eth_mdio_o=0 with eth_mdio_t=0 for TA bit 2.
REQ-023 TA on write: SHALL accept 2 bits without checking their value.
REQ-024 RDATA: SHALL drive reg[REGAD] MSB first over 16 bit periods.
REQ-025 Drive timing: each driven bit SHALL change exactly 1 clock cycle after the detected rising edge and SHALL hold until the next such update.
REQ-026 RDATA end: SHALL release (eth_mdio_t=1) 1 clock cycle after the 16th data rising edge, then go to IDLE.
REQ-027 WDATA: SHALL shift 16 bits; after the 16th bit, a non-foreign frame SHALL update the register file and pulse reg_wr_valid 1 cycle later.
REQ-028 Foreign frames SHALL never drive MDIO, never write registers, and never pulse reg_wr_valid.
REQ-029 Register file SHALL have 32 x 16 bits; unlisted registers reset to 16'h0000.
REQ-030 reg0 SHALL reset to 16'h1140; reg1 SHALL be read-only 16'h796D; reg2 SHALL reset to PHY_ID1; reg3 SHALL reset to PHY_ID2.
REQ-031 Writes to reg1, reg2 and reg3 SHALL be ignored, but SHALL still pulse reg_wr_valid.
REQ-032 Writing reg0 with bit15=1 SHALL restore all registers to their reset values; bit15 SHALL always read 0.
REQ-033 After every completed frame (read or write), the FSM SHALL return to IDLE with the preamble count cleared; no frame SHALL start without a fresh 32-bit preamble.
REQ-034 Back-to-back transactions SHALL be supported with no idle MDC cycles between frames.

Reset
REQ-035 While reset=1, the FSM SHALL be in IDLE, the preamble count and synchronisers SHALL be cleared, and the register file SHALL hold its reset values.
REQ-036 While reset=1, outputs SHALL be eth_mdio_t=1, eth_mdio_o=0, reg_wr_valid=0, reg_wr_addr=0 and reg_wr_data=0.
REQ-037 Reset asserted mid-frame SHALL release MDIO on the next clock and SHALL discard the partial frame.

Verification
REQ-038 Read reg2 at PHY_ADDR 7 after reset -> TA bit 2 driven 0, then data 16'h0141 MSB first, then released.
REQ-039 Write reg5=16'hA5A5, then read reg5 -> reg_wr_valid pulses once with addr 5 and data A5A5; the read returns 16'hA5A5.
REQ-040 Read with PHYAD 3 -> eth_mdio_t stays 1 for the whole frame and no reg_wr_valid pulse occurs.
REQ-041 Only 31 preamble ones then ST -> frame ignored; an immediately following frame with a full preamble succeeds.
REQ-042 Write reg0=16'h8000 after reg5 has been written -> reg5 reads 0000 and reg0 reads 16'h1140.
REQ-043 Reset asserted at RDATA bit 8 -> eth_mdio_t=1 on the next clock and all registers return to their reset values.
